// File: rtl/box_animator.sv
// box_animator: autonomous sequencer that animates a bouncing 4x4 box by
// driving the box drawer's load/plot/coordinate/colour inputs. Each move
// erases the box (black redraw), steps it one pixel diagonally with edge
// bounce, then redraws it in the selected colour.
module box_animator #(
  parameter int         FRAME_CYCLES    = 833334,
  parameter logic [3:0] FRAMES_PER_MOVE = 4'd15,
  parameter logic [6:0] X_MAX           = 7'd124,
  parameter logic [6:0] Y_MAX           = 7'd116,
  parameter logic [6:0] X0              = 7'd0,
  parameter logic [6:0] Y0              = 7'd0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [2:0] iColour,
  input  logic       iDone,
  output logic       oLoadX,
  output logic       oPlotBox,
  output logic [6:0] oXY_Coord,
  output logic [2:0] oColour,
  output logic [6:0] oX,
  output logic [6:0] oY,
  output logic       oBusy
);

  localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(FRAME_CYCLES - 1);

  typedef enum logic [3:0] {
    S_LDX1        = 4'd0,
    S_LDX2        = 4'd1,
    S_LDY1        = 4'd2,
    S_LDY2        = 4'd3,
    S_PLOT1       = 4'd4,
    S_PLOT2       = 4'd5,
    S_WAIT_DONE   = 4'd6,
    S_WAIT_FRAMES = 4'd7,
    S_MOVE        = 4'd8
  } state_t;

  typedef enum logic {
    MODE_DRAW  = 1'b0,
    MODE_ERASE = 1'b1
  } mode_t;

  state_t        state_r;
  mode_t         mode_r;
  logic          armed_r;     // 0 only in the cycle(s) directly after reset
  logic [6:0]    x_r;
  logic [6:0]    y_r;
  logic          dx_r;
  logic          dy_r;
  logic [2:0]    colour_r;
  logic [CW-1:0] cyc_r;
  logic [3:0]    frame_r;
  logic          load_x_r;
  logic          plot_r;
  logic [6:0]    coord_r;
  logic          busy_r;

  logic [6:0]    x_mv_s;
  logic [6:0]    y_mv_s;
  logic          dx_mv_s;
  logic          dy_mv_s;
  logic          cyc_last_s;
  logic [3:0]    frame_inc_s;

  // Next x position and direction for a MOVE step, bouncing at 0 and X_MAX.
  always_comb begin
    x_mv_s  = x_r;
    dx_mv_s = dx_r;
    if (dx_r && (x_r == X_MAX)) begin
      dx_mv_s = 1'b0;
      x_mv_s  = x_r - 7'd1;
    end else if (!dx_r && (x_r == 7'd0)) begin
      dx_mv_s = 1'b1;
      x_mv_s  = x_r + 7'd1;
    end else if (dx_r) begin
      x_mv_s  = x_r + 7'd1;
    end else begin
      x_mv_s  = x_r - 7'd1;
    end
  end

  // Next y position and direction for a MOVE step, bouncing at 0 and Y_MAX.
  always_comb begin
    y_mv_s  = y_r;
    dy_mv_s = dy_r;
    if (dy_r && (y_r == Y_MAX)) begin
      dy_mv_s = 1'b0;
      y_mv_s  = y_r - 7'd1;
    end else if (!dy_r && (y_r == 7'd0)) begin
      dy_mv_s = 1'b1;
      y_mv_s  = y_r + 7'd1;
    end else if (dy_r) begin
      y_mv_s  = y_r + 7'd1;
    end else begin
      y_mv_s  = y_r - 7'd1;
    end
  end

  // Frame-tick helpers for the WAIT_FRAMES dwell.
  always_comb begin
    cyc_last_s  = (cyc_r == CYC_LAST);
    frame_inc_s = frame_r + 4'd1;
  end

  // Main sequencer: state, position, counters and registered drawer strobes.
  // Strobe registers are loaded on the edge that enters a state, so they are
  // valid for the whole cycle that state is visible.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r  <= S_LDX1;
      mode_r   <= MODE_DRAW;
      armed_r  <= 1'b0;
      x_r      <= X0;
      y_r      <= Y0;
      dx_r     <= 1'b1;
      dy_r     <= 1'b1;
      colour_r <= 3'd0;
      cyc_r    <= '0;
      frame_r  <= 4'd0;
      load_x_r <= 1'b0;
      plot_r   <= 1'b0;
      coord_r  <= 7'd0;
      busy_r   <= 1'b0;
    end else begin
      case (state_r)
        S_LDX1: begin
          if (!armed_r) begin
            // First edge after reset: start the initial draw transfer.
            armed_r  <= 1'b1;
            colour_r <= iColour;
            load_x_r <= 1'b1;
            coord_r  <= x_r;
            busy_r   <= 1'b1;
          end else begin
            state_r  <= S_LDX2;
          end
        end
        S_LDX2: begin
          state_r  <= S_LDY1;
          load_x_r <= 1'b0;
          coord_r  <= y_r;
        end
        S_LDY1: begin
          state_r <= S_LDY2;
        end
        S_LDY2: begin
          state_r <= S_PLOT1;
          plot_r  <= 1'b1;
        end
        S_PLOT1: begin
          state_r <= S_PLOT2;
        end
        S_PLOT2: begin
          state_r <= S_WAIT_DONE;
          plot_r  <= 1'b0;
        end
        S_WAIT_DONE: begin
          if (iDone) begin
            busy_r  <= 1'b0;
            state_r <= (mode_r == MODE_DRAW) ? S_WAIT_FRAMES : S_MOVE;
          end
        end
        S_WAIT_FRAMES: begin
          if (cyc_last_s) begin
            cyc_r <= '0;
            if (frame_inc_s == FRAMES_PER_MOVE) begin
              frame_r  <= 4'd0;
              mode_r   <= MODE_ERASE;
              colour_r <= iColour;
              state_r  <= S_LDX1;
              load_x_r <= 1'b1;
              coord_r  <= x_r;
              busy_r   <= 1'b1;
            end else begin
              frame_r <= frame_inc_s;
            end
          end else begin
            cyc_r <= cyc_r + CW'(1);
          end
        end
        S_MOVE: begin
          x_r      <= x_mv_s;
          y_r      <= y_mv_s;
          dx_r     <= dx_mv_s;
          dy_r     <= dy_mv_s;
          mode_r   <= MODE_DRAW;
          colour_r <= iColour;
          state_r  <= S_LDX1;
          load_x_r <= 1'b1;
          coord_r  <= x_mv_s;
          busy_r   <= 1'b1;
        end
        default: begin
          state_r  <= S_LDX1;
          armed_r  <= 1'b0;
          load_x_r <= 1'b0;
          plot_r   <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  // Erase passes always send black; draw passes send the latched colour.
  assign oColour   = (mode_r == MODE_DRAW) ? colour_r : 3'd0;
  assign oLoadX    = load_x_r;
  assign oPlotBox  = plot_r;
  assign oXY_Coord = coord_r;
  assign oBusy     = busy_r;
  assign oX        = x_r;
  assign oY        = y_r;

endmodule

// File: tb/tb_box_animator.sv
// Bench for box_animator with a small screen (X_MAX=3, Y_MAX=2) and short
// frames (4 cycles, 2 frames per move).
module tb_box_animator;

  logic       clk;
  logic       resetn;
  logic [2:0] iColour;
  logic       iDone;
  logic       oLoadX;
  logic       oPlotBox;
  logic [6:0] oXY_Coord;
  logic [2:0] oColour;
  logic [6:0] oX;
  logic [6:0] oY;
  logic       oBusy;

  box_animator #(
    .FRAME_CYCLES   (4),
    .FRAMES_PER_MOVE(4'd2),
    .X_MAX          (7'd3),
    .Y_MAX          (7'd2),
    .X0             (7'd0),
    .Y0             (7'd0)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .iColour  (iColour),
    .iDone    (iDone),
    .oLoadX   (oLoadX),
    .oPlotBox (oPlotBox),
    .oXY_Coord(oXY_Coord),
    .oColour  (oColour),
    .oX       (oX),
    .oY       (oY),
    .oBusy    (oBusy)
  );

  typedef struct {
    logic       rst;
    logic [2:0] col;
    logic       ldx;
    logic       plot;
    logic [6:0] coord;
    logic [2:0] ocol;
    logic       busy;
    logic [6:0] x;
    logic [6:0] y;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp;
  int   n_err;
  int   done_mode;   // 0: drawer model, 1: iDone held 1, 2: iDone held 0
  int   drw_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drawer model: iDone rises 17 cycles after the last plot cycle.
  initial begin
    drw_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (done_mode == 1) begin
        iDone = 1'b1;
      end else if (done_mode == 2) begin
        iDone = 1'b0;
      end else if (oPlotBox) begin
        iDone   = 1'b0;
        drw_cnt = 17;
      end else if (drw_cnt > 0) begin
        drw_cnt = drw_cnt - 1;
        if (drw_cnt == 0) iDone = 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic add_vec(input logic r, input logic [2:0] c, input logic l, input logic p,
                         input logic [6:0] co, input logic [2:0] oc, input logic b,
                         input logic [6:0] ex, input logic [6:0] ey);
    vec_t v;
    v.rst = r; v.col = c; v.ldx = l; v.plot = p; v.coord = co;
    v.ocol = oc; v.busy = b; v.x = ex; v.y = ey;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  // Wait until the box position changes; returns 0 on timeout.
  task automatic wait_move(output bit ok);
    logic [6:0] px;
    logic [6:0] py;
    px = oX;
    py = oY;
    ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      tick();
      if (oX != px || oY != py) ok = 1'b1;
    end
  endtask

  initial begin
    bit         ok;
    bit         found;
    bit         prev_plot;
    logic [6:0] xs[13];
    logic [6:0] ys[13];

    n_cmp     = 0;
    n_err     = 0;
    done_mode = 1;
    iDone     = 1'b0;
    resetn    = 1'b0;
    iColour   = 3'd5;

    // Reset, first draw at (0,0), frame dwell, erase, MOVE, draw at (1,1);
    // iDone held high so each WAIT_DONE lasts one cycle.
    add_vec(1'b0, 3'd5, 1'b0, 1'b0, 7'd0, 3'd0, 1'b0, 7'd0, 7'd0);
    add_vec(1'b0, 3'd5, 1'b0, 1'b0, 7'd0, 3'd0, 1'b0, 7'd0, 7'd0);
    add_vec(1'b1, 3'd5, 1'b1, 1'b0, 7'd0, 3'd5, 1'b1, 7'd0, 7'd0);
    add_vec(1'b1, 3'd5, 1'b1, 1'b0, 7'd0, 3'd5, 1'b1, 7'd0, 7'd0);
    add_vec(1'b1, 3'd2, 1'b0, 1'b0, 7'd0, 3'd5, 1'b1, 7'd0, 7'd0);
    add_vec(1'b1, 3'd2, 1'b0, 1'b0, 7'd0, 3'd5, 1'b1, 7'd0, 7'd0);
    add_vec(1'b1, 3'd2, 1'b0, 1'b1, 7'd0, 3'd5, 1'b1, 7'd0, 7'd0);
    add_vec(1'b1, 3'd2, 1'b0, 1'b1, 7'd0, 3'd5, 1'b1, 7'd0, 7'd0);
    add_vec(1'b1, 3'd2, 1'b0, 1'b0, 7'd0, 3'd5, 1'b1, 7'd0, 7'd0);
    for (int i = 0; i < 8; i++)
      add_vec(1'b1, 3'd2, 1'b0, 1'b0, 7'd0, 3'd5, 1'b0, 7'd0, 7'd0);
    add_vec(1'b1, 3'd5, 1'b1, 1'b0, 7'd0, 3'd0, 1'b1, 7'd0, 7'd0);
    add_vec(1'b1, 3'd5, 1'b1, 1'b0, 7'd0, 3'd0, 1'b1, 7'd0, 7'd0);
    add_vec(1'b1, 3'd5, 1'b0, 1'b0, 7'd0, 3'd0, 1'b1, 7'd0, 7'd0);
    add_vec(1'b1, 3'd5, 1'b0, 1'b0, 7'd0, 3'd0, 1'b1, 7'd0, 7'd0);
    add_vec(1'b1, 3'd5, 1'b0, 1'b1, 7'd0, 3'd0, 1'b1, 7'd0, 7'd0);
    add_vec(1'b1, 3'd5, 1'b0, 1'b1, 7'd0, 3'd0, 1'b1, 7'd0, 7'd0);
    add_vec(1'b1, 3'd5, 1'b0, 1'b0, 7'd0, 3'd0, 1'b1, 7'd0, 7'd0);
    add_vec(1'b1, 3'd5, 1'b0, 1'b0, 7'd0, 3'd0, 1'b0, 7'd0, 7'd0);
    add_vec(1'b1, 3'd5, 1'b1, 1'b0, 7'd1, 3'd5, 1'b1, 7'd1, 7'd1);
    add_vec(1'b1, 3'd5, 1'b1, 1'b0, 7'd1, 3'd5, 1'b1, 7'd1, 7'd1);
    add_vec(1'b1, 3'd5, 1'b0, 1'b0, 7'd1, 3'd5, 1'b1, 7'd1, 7'd1);
    add_vec(1'b1, 3'd5, 1'b0, 1'b0, 7'd1, 3'd5, 1'b1, 7'd1, 7'd1);
    add_vec(1'b1, 3'd5, 1'b0, 1'b1, 7'd1, 3'd5, 1'b1, 7'd1, 7'd1);
    add_vec(1'b1, 3'd5, 1'b0, 1'b1, 7'd1, 3'd5, 1'b1, 7'd1, 7'd1);
    add_vec(1'b1, 3'd5, 1'b0, 1'b0, 7'd1, 3'd5, 1'b1, 7'd1, 7'd1);
    add_vec(1'b1, 3'd5, 1'b0, 1'b0, 7'd1, 3'd5, 1'b0, 7'd1, 7'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      resetn  = vecs[i].rst;
      iColour = vecs[i].col;
      tick();
      chk("ldx",   i, 8'(oLoadX),    8'(vecs[i].ldx));
      chk("plot",  i, 8'(oPlotBox),  8'(vecs[i].plot));
      chk("coord", i, 8'(oXY_Coord), 8'(vecs[i].coord));
      chk("col",   i, 8'(oColour),   8'(vecs[i].ocol));
      chk("busy",  i, 8'(oBusy),     8'(vecs[i].busy));
      chk("x",     i, 8'(oX),        8'(vecs[i].x));
      chk("y",     i, 8'(oY),        8'(vecs[i].y));
    end

    // iDone held low: the block parks in WAIT_DONE with strobes low, busy high.
    done_mode = 2;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i >= 6) begin
        chk("hold_ldx",  i, 8'(oLoadX),   8'd0);
        chk("hold_plot", i, 8'(oPlotBox), 8'd0);
        chk("hold_busy", i, 8'(oBusy),    8'd1);
      end
    end

    // Thirteen moves with the drawer model, including the (0,0) corner bounce.
    xs = '{7'd1, 7'd2, 7'd3, 7'd2, 7'd1, 7'd0, 7'd1, 7'd2, 7'd3, 7'd2, 7'd1, 7'd0, 7'd1};
    ys = '{7'd1, 7'd2, 7'd1, 7'd0, 7'd1, 7'd2, 7'd1, 7'd0, 7'd1, 7'd2, 7'd1, 7'd0, 7'd1};
    done_mode = 0;
    iColour   = 3'd3;
    do_reset();
    for (int m = 0; m < 13; m++) begin
      wait_move(ok);
      chk("move_seen", m, 8'(ok), 8'd1);
      if (ok) begin
        chk("mv_x",     m, 8'(oX),        8'(xs[m]));
        chk("mv_y",     m, 8'(oY),        8'(ys[m]));
        chk("mv_ldx",   m, 8'(oLoadX),    8'd1);
        chk("mv_coord", m, 8'(oXY_Coord), 8'(xs[m]));
        chk("mv_col",   m, 8'(oColour),   8'd3);
        chk("x_bound",  m, 8'(oX <= 7'd3), 8'd1);
        chk("y_bound",  m, 8'(oY <= 7'd2), 8'd1);
      end
    end

    // Reset asserted during PLOT1 of the erase at (2,2).
    do_reset();
    found     = 1'b0;
    prev_plot = 1'b0;
    for (int k = 0; k < 1500 && !found; k++) begin
      tick();
      if (oPlotBox && !prev_plot && oX == 7'd2 && oY == 7'd2 && oColour == 3'd0)
        found = 1'b1;
      prev_plot = oPlotBox;
    end
    chk("erase22_found", 0, 8'(found), 8'd1);
    if (found) begin
      resetn = 1'b0;
      tick();
      chk("rst_ldx",   0, 8'(oLoadX),    8'd0);
      chk("rst_plot",  0, 8'(oPlotBox),  8'd0);
      chk("rst_coord", 0, 8'(oXY_Coord), 8'd0);
      chk("rst_col",   0, 8'(oColour),   8'd0);
      chk("rst_busy",  0, 8'(oBusy),     8'd0);
      chk("rst_x",     0, 8'(oX),        8'd0);
      chk("rst_y",     0, 8'(oY),        8'd0);
      resetn = 1'b1;
      tick();
      chk("rel_ldx",   0, 8'(oLoadX),    8'd1);
      chk("rel_coord", 0, 8'(oXY_Coord), 8'd0);
      chk("rel_col",   0, 8'(oColour),   8'd3);
      chk("rel_busy",  0, 8'(oBusy),     8'd1);
      wait_move(ok);
      chk("rel_move_seen", 0, 8'(ok), 8'd1);
      chk("rel_mv_x",      0, 8'(oX), 8'd1);
      chk("rel_mv_y",      0, 8'(oY), 8'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/box_animator.md
# box_animator

Autonomous sequencer that drives the 4x4 box drawer to animate a bouncing box. Each step it erases the box at the current position by redrawing it in black, moves the box one pixel diagonally, bounces at screen edges, and redraws it in the selected colour. It sits directly upstream of the box drawer and drives that block's load, plot, coordinate and colour inputs. It waits for the drawer's done flag before starting the next transfer.

## Interface
Parameters:
- FRAME_CYCLES, 833334: clk cycles per frame tick (50 MHz / 60 Hz).
- FRAMES_PER_MOVE, 4'd15: frame ticks between moves.
- X_MAX, 7'd124: largest legal box x (top-left corner).
- Y_MAX, 7'd116: largest legal box y (top-left corner).
- X0, 7'd0: reset x position.
- Y0, 7'd0: reset y position.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset; synchronous, active-low. Clock is clk.
- iColour  in  3  box colour; sampled once at the start of each draw transfer.
- iDone  in  1  drawer done flag; high while the drawer is idle after finishing a box.
- oLoadX  out  1  drawer load-x strobe.
- oPlotBox  out  1  drawer plot strobe.
- oXY_Coord  out  7  coordinate bus to the drawer; carries x during load-x, y afterwards.
- oColour  out  3  colour sent to the drawer.
- oX  out  7  current box x (debug).
- oY  out  7  current box y (debug).
- oBusy  out  1  high while a transfer is in progress (from LDX1 through WAIT_DONE).

## Operation
- Registers:
  - x, y (7 bits each).
  - dx, dy: direction bits, 1 = increasing.
  - colour register (3 bits).
  - mode: DRAW or ERASE.
  - cycle counter: ceil(log2 FRAME_CYCLES) bits.
  - frame counter: 4 bits.
- Reset values: x=X0, y=Y0, dx=1, dy=1, mode=DRAW, both counters 0, state LDX1, colour register=0.
- Transfer states (one box per pass): LDX1 -> LDX2 -> LDY1 -> LDY2 -> PLOT1 -> PLOT2 -> WAIT_DONE.
  - LDX1, LDX2: oLoadX=1, oXY_Coord=x.
  - LDY1, LDY2: oLoadX=0, oXY_Coord=y.
  - PLOT1, PLOT2: oPlotBox=1, oXY_Coord=y.
  - WAIT_DONE: all strobes 0, oXY_Coord=y. Leave when iDone=1.
- oColour:
  - mode DRAW: equals the colour register, which is loaded from iColour on entry to LDX1.
  - mode ERASE: 3'b000.
  - oColour is stable from LDX1 through WAIT_DONE.
- After WAIT_DONE:
  - mode DRAW -> WAIT_FRAMES.
  - mode ERASE -> MOVE.
- WAIT_FRAMES:
  - Cycle counter counts 0..FRAME_CYCLES-1 and wraps. Each wrap increments the frame counter.
  - When the frame counter reaches FRAMES_PER_MOVE: clear both counters, set mode=ERASE, go to LDX1.
- MOVE (one cycle), per axis (x shown; y identical with dy, Y_MAX):
  - dx=1 and x==X_MAX: dx<=0, x<=x-1.
  - dx=0 and x==0: dx<=1, x<=x+1.
  - otherwise: x<=x±1 per dx.
  - Then set mode=DRAW and go to LDX1.
- Boundary condition: x and y never leave [0,X_MAX] and [0,Y_MAX]. Both axes may bounce in the same MOVE cycle (corner).
- iDone is ignored outside WAIT_DONE. If iDone is already high on entry to WAIT_DONE, exit on the next edge.
- oX and oY always reflect the x and y registers.

## Timing
- State transitions occur on posedge clk, with all outputs registered or decoded from state.
- After reset release, the first cycle is LDX1: oLoadX=1, oXY_Coord=X0.
- Transfer timing:
  - Strobe phase is exactly 6 cycles: 2 load-x, 2 load-y, 2 plot.
  - Followed by at least 1 WAIT_DONE cycle.
- Move period: FRAMES_PER_MOVE*FRAME_CYCLES cycles in WAIT_FRAMES, plus the erase transfer, MOVE (1 cycle) and the draw transfer.
- Reset mid-operation:
  - Next cycle is LDX1 with reset values.
  - oLoadX and oPlotBox must not glitch high in the reset cycle itself; all outputs are 0 there except oX/oY=X0/Y0.
- oBusy is 1 in the 7+ transfer states and 0 in WAIT_FRAMES and MOVE.

## Test plan
Use parameters FRAME_CYCLES=4, FRAMES_PER_MOVE=2, X_MAX=3, Y_MAX=2 unless stated. The drawer model asserts iDone 17 cycles after PLOT2.
- Reset release with iColour=3'b101 -> oLoadX=1 for cycles 0-1 with coord 0; coord 0 for cycles 2-5; oPlotBox=1 for cycles 4-5; oColour=101 throughout.
- After the first draw -> WAIT_FRAMES lasts exactly 8 cycles; then an erase transfer at (0,0) with oColour=000; then MOVE gives (1,1); then a draw at (1,1).
- Run 12 moves -> x sequence 1,2,3,2,1,0,1,...; y sequence 1,2,1,0,1,...; neither ever exceeds X_MAX/Y_MAX.
- Hold iDone=1 constantly -> WAIT_DONE lasts exactly 1 cycle per transfer.
- Hold iDone=0 -> the block stays in WAIT_DONE indefinitely with strobes 0 and oBusy=1.
- Assert resetn=0 during PLOT1 of an erase at (2,2) -> the next cycle is LDX1 at (X0,Y0) with mode DRAW and dx=dy=1.
